// File: rtl/mem_ctrl_burst.sv
// rtl/mem_ctrl_burst.sv - single-port memory controller with command queue and incrementing read bursts
//
// Buffers commands in a small FIFO and executes them in order at one memory
// access per cycle: writes are a single beat, reads are bursts of blen+1
// beats at consecutive (wrapping) addresses. Read data comes back on
// rdata_sys with a one-cycle rvalid_sys strobe per beat.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   cmd_valid_sys / ready_sys  command handshake (accept on valid && ready)
//   we_sys, addr_sys,
//   wdata_sys, blen_sys        command fields (blen = beats - 1, reads only)
//   rdata_sys, rvalid_sys      read return, no backpressure
//   idle_sys                   queue empty, nothing issuing, no read in flight
//   ce_mem, we_mem, addr_mem,
//   datai_mem                  registered memory core access
//   datao_mem                  memory read data, RD_LAT cycles after ce_mem

module mem_ctrl_burst #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4,
    parameter int RD_LAT     = 1,
    localparam int BL_W      = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_sys,
    input  logic              we_sys,
    input  logic [ADDR_W-1:0] addr_sys,
    input  logic [DATA_W-1:0] wdata_sys,
    input  logic [BL_W-1:0]   blen_sys,
    output logic              ready_sys,
    output logic [DATA_W-1:0] rdata_sys,
    output logic              rvalid_sys,
    output logic              idle_sys,
    output logic              ce_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    input  logic [DATA_W-1:0] datao_mem
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = BL_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic              fifo_we    [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
    logic [BL_W-1:0]   fifo_blen  [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // Combinational so a full queue refuses the offer in the same cycle;
    // a pop on the following edge only reopens it one cycle later.
    assign ready_sys = !reset && !full;
    assign push      = cmd_valid_sys && ready_sys;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we[wr_ptr]    <= we_sys;
            fifo_addr[wr_ptr]  <= addr_sys;
            fifo_wdata[wr_ptr] <= wdata_sys;
            fifo_blen[wr_ptr]  <= blen_sys;
        end
    end

    // ------------------------------------------------------------------
    // Execution FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic              beat;
    logic              last_beat;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [BC_W-1:0]   beat_cnt;

    assign last_beat = (beat_cnt == BC_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Stay in ACCESS when another command is queued so the next
                // command's first beat follows the last beat without a gap.
                if (last_beat && empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        beat = 1'b0;
        pop  = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
            end
            ACCESS: begin
                beat = 1'b1;
                pop  = last_beat && !empty;
            end
            default: begin
                beat = 1'b0;
                pop  = 1'b0;
            end
        endcase
    end

    // Active command registers. A pop on the last beat reloads them on the
    // same edge that registers that last beat onto the memory bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            beat_cnt  <= '0;
        end else if (pop) begin
            cur_we    <= fifo_we[rd_ptr];
            cur_addr  <= fifo_addr[rd_ptr];
            cur_wdata <= fifo_wdata[rd_ptr];
            if (fifo_we[rd_ptr]) begin
                beat_cnt <= BC_W'(1);
            end else begin
                beat_cnt <= {1'b0, fifo_blen[rd_ptr]} + BC_W'(1);
            end
        end else if (beat) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            beat_cnt <= beat_cnt - BC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered memory interface
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_mem    <= 1'b0;
            we_mem    <= 1'b0;
            addr_mem  <= '0;
            datai_mem <= '0;
        end else if (beat) begin
            ce_mem    <= 1'b1;
            we_mem    <= cur_we;
            addr_mem  <= cur_addr;
            datai_mem <= cur_we ? cur_wdata : '0;
        end else begin
            ce_mem <= 1'b0;
            we_mem <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read return
    // ------------------------------------------------------------------
    // vld_sr[k] is set in cycle T+1+k for a read issued in cycle T, so
    // vld_sr[RD_LAT-1] marks the cycle datao_mem is valid and the top
    // stage is the rvalid_sys pulse itself.
    logic [RD_LAT:0]   vld_sr;
    logic              rd_issued;

    assign rd_issued  = ce_mem && !we_mem;
    assign rvalid_sys = vld_sr[RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr    <= '0;
            rdata_sys <= '0;
        end else begin
            vld_sr <= {vld_sr[RD_LAT-1:0], rd_issued};
            if (vld_sr[RD_LAT-1]) begin
                rdata_sys <= datao_mem;
            end
        end
    end

    // A read on the bus this cycle has not reached the shift register yet,
    // so ce_mem is included to keep idle low across that gap.
    assign idle_sys = empty && (state == IDLE) && !ce_mem && (vld_sr == '0);

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// tb/tb_mem_ctrl_burst.sv - directed self-checking bench for mem_ctrl_burst
module tb_mem_ctrl_burst;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_init = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Instance with RD_LAT=1
    logic       cmd_valid = 1'b0;
    logic       we = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [1:0] blen = 2'd0;
    logic       ready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       idle;
    logic       ce_mem;
    logic       we_mem;
    logic [7:0] addr_mem;
    logic [7:0] datai_mem;
    logic [7:0] datao_mem;

    // Instance with RD_LAT=3
    logic       cmd_valid3 = 1'b0;
    logic       we3 = 1'b0;
    logic [7:0] addr3 = 8'h00;
    logic [7:0] wdata3 = 8'h00;
    logic [1:0] blen3 = 2'd0;
    logic       ready3;
    logic [7:0] rdata3;
    logic       rvalid3;
    logic       idle3;
    logic       ce_mem3;
    logic       we_mem3;
    logic [7:0] addr_mem3;
    logic [7:0] datai_mem3;
    logic [7:0] datao_mem3;

    mem_ctrl_burst #(
        .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .MAX_BURST(4), .RD_LAT(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid_sys(cmd_valid), .we_sys(we), .addr_sys(addr),
        .wdata_sys(wdata), .blen_sys(blen), .ready_sys(ready),
        .rdata_sys(rdata), .rvalid_sys(rvalid), .idle_sys(idle),
        .ce_mem(ce_mem), .we_mem(we_mem), .addr_mem(addr_mem),
        .datai_mem(datai_mem), .datao_mem(datao_mem)
    );

    mem_ctrl_burst #(
        .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .MAX_BURST(4), .RD_LAT(3)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid_sys(cmd_valid3), .we_sys(we3), .addr_sys(addr3),
        .wdata_sys(wdata3), .blen_sys(blen3), .ready_sys(ready3),
        .rdata_sys(rdata3), .rvalid_sys(rvalid3), .idle_sys(idle3),
        .ce_mem(ce_mem3), .we_mem(we_mem3), .addr_mem(addr_mem3),
        .datai_mem(datai_mem3), .datao_mem(datao_mem3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory core model: preset to addr ^ 0x5A, latency 1 for u_dut and 3 for u_dut3
    logic [7:0] mem [256];
    logic [7:0] rd1;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (ce_mem && we_mem) begin
            mem[addr_mem] <= datai_mem;
        end
        if (ce_mem && !we_mem) rd1 <= mem[addr_mem];
        if (ce_mem3 && !we_mem3) p3[0] <= mem[addr_mem3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign datao_mem  = rd1;
    assign datao_mem3 = p3[2];

    // Bus / return logs, sampled at the falling edge; cyc = k means cycle after edge k
    int          ce_cyc [$];
    logic [16:0] ce_bus [$];
    int          rv_cyc [$];
    logic [7:0]  rv_data [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (ce_mem) begin
                ce_cyc.push_back(cyc);
                ce_bus.push_back({we_mem, addr_mem, datai_mem});
            end
            if (rvalid) begin
                rv_cyc.push_back(cyc);
                rv_data.push_back(rdata);
            end
        end
    end

    task automatic clear_logs();
        ce_cyc.delete();
        ce_bus.delete();
        rv_cyc.delete();
        rv_data.delete();
    endtask

    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [1:0] b, output int acc, output logic ok);
        @(negedge clk);
        cmd_valid = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        blen = b;
        ok = ready;
        acc = cyc + 1;
    endtask

    task automatic drop();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_timeout idle=%b after %0d cycles, expected 1", tag, idle, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ce_mem, we_mem, addr_mem, datai_mem, rdata, rvalid, ready, idle} !== {2'b00, 8'h00, 8'h00, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL reset_outputs got ce=%b we=%b addr=%h di=%h rd=%h rv=%b rdy=%b idle=%b, expected 0 0 00 00 00 0 0 1",
                     ce_mem, we_mem, addr_mem, datai_mem, rdata, rvalid, ready, idle);
        end
        checks++;
        if ({ce_mem3, rvalid3, ready3, idle3} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_outputs_lat3 got ce=%b rv=%b rdy=%b idle=%b, expected 0 0 0 1",
                     ce_mem3, rvalid3, ready3, idle3);
        end
        reset = 1'b0;
        mem_init = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b expected 1", ready);
        end
    endtask

    task automatic test_write_read();
        int a, a1;
        logic ok;
        clear_logs();
        send(1'b1, 8'h10, 8'hA5, 2'd0, a, ok);
        send(1'b0, 8'h10, 8'h00, 2'd0, a1, ok);
        drop();
        wait_quiet(50, "wr_rd");
        checks++;
        if (ce_cyc.size() != 2) begin
            errors++;
            $display("FAIL wr_rd_beats got %0d expected 2", ce_cyc.size());
        end else begin
            checks++;
            if (ce_cyc[0] != a + 2 || ce_bus[0] !== {1'b1, 8'h10, 8'hA5}) begin
                errors++;
                $display("FAIL wr_rd_write_beat got cyc+%0d bus=%h expected cyc+2 bus=%h",
                         ce_cyc[0] - a, ce_bus[0], {1'b1, 8'h10, 8'hA5});
            end
            checks++;
            if (ce_cyc[1] != a + 3 || ce_bus[1] !== {1'b0, 8'h10, 8'h00}) begin
                errors++;
                $display("FAIL wr_rd_read_beat got cyc+%0d bus=%h expected cyc+3 bus=%h",
                         ce_cyc[1] - a, ce_bus[1], {1'b0, 8'h10, 8'h00});
            end
        end
        checks++;
        if (rv_data.size() != 1) begin
            errors++;
            $display("FAIL wr_rd_rvalid_count got %0d expected 1", rv_data.size());
        end else begin
            checks++;
            if (rv_data[0] !== 8'hA5 || rv_cyc[0] != a + 5) begin
                errors++;
                $display("FAIL wr_rd_rdata got %h at cyc+%0d expected a5 at cyc+5", rv_data[0], rv_cyc[0] - a);
            end
        end
    endtask

    task automatic test_burst();
        int a, t;
        logic ok;
        logic [16:0] exp_bus;
        clear_logs();
        send(1'b1, 8'h20, 8'h01, 2'd0, a, ok);
        send(1'b1, 8'h21, 8'h02, 2'd0, t, ok);
        send(1'b1, 8'h22, 8'h03, 2'd0, t, ok);
        send(1'b1, 8'h23, 8'h04, 2'd0, t, ok);
        send(1'b0, 8'h20, 8'h00, 2'd3, t, ok);
        drop();
        wait_quiet(60, "burst");
        checks++;
        if (ce_cyc.size() != 8) begin
            errors++;
            $display("FAIL burst_beats got %0d expected 8", ce_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_bus = (i < 4) ? {1'b1, 8'h20 + 8'(i), 8'(i + 1)} : {1'b0, 8'h20 + 8'(i - 4), 8'h00};
                checks++;
                if (ce_cyc[i] != a + 2 + i || ce_bus[i] !== exp_bus) begin
                    errors++;
                    $display("FAIL burst_beat%0d got cyc+%0d bus=%h expected cyc+%0d bus=%h",
                             i, ce_cyc[i] - a, ce_bus[i], 2 + i, exp_bus);
                end
            end
        end
        checks++;
        if (rv_data.size() != 4) begin
            errors++;
            $display("FAIL burst_rvalid_count got %0d expected 4", rv_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rv_data[i] !== 8'(i + 1) || rv_cyc[i] != a + 8 + i) begin
                    errors++;
                    $display("FAIL burst_rdata%0d got %h at cyc+%0d expected %h at cyc+%0d",
                             i, rv_data[i], rv_cyc[i] - a, 8'(i + 1), 8 + i);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int a;
        logic ok;
        logic [7:0] ea;
        clear_logs();
        send(1'b0, 8'hFE, 8'h00, 2'd3, a, ok);
        drop();
        wait_quiet(40, "wrap");
        checks++;
        if (ce_cyc.size() != 4 || rv_data.size() != 4) begin
            errors++;
            $display("FAIL wrap_counts got beats=%0d rvalids=%0d expected 4 4", ce_cyc.size(), rv_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ea = 8'hFE + 8'(i);
                checks++;
                if (ce_bus[i] !== {1'b0, ea, 8'h00} || ce_cyc[i] != a + 2 + i) begin
                    errors++;
                    $display("FAIL wrap_addr%0d got bus=%h at cyc+%0d expected addr %h at cyc+%0d",
                             i, ce_bus[i], ce_cyc[i] - a, ea, 2 + i);
                end
                checks++;
                if (rv_data[i] !== (ea ^ 8'h5A)) begin
                    errors++;
                    $display("FAIL wrap_rdata%0d got %h expected %h", i, rv_data[i], ea ^ 8'h5A);
                end
            end
        end
    endtask

    task automatic test_full();
        int acc [6];
        logic ok [6];
        logic exp_ok [6];
        int n_ok;
        logic [7:0] ea;
        exp_ok = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_logs();
        for (int k = 0; k < 6; k++) send(1'b0, 8'h40 + 8'(16 * k), 8'h00, 2'd3, acc[k], ok[k]);
        drop();
        wait_quiet(200, "full");
        n_ok = 0;
        for (int k = 0; k < 6; k++) begin
            if (ok[k] === 1'b1) n_ok++;
            checks++;
            if (ok[k] !== exp_ok[k]) begin
                errors++;
                $display("FAIL full_ready_cmd%0d got %b expected %b", k, ok[k], exp_ok[k]);
            end
        end
        checks++;
        if (n_ok != 5) begin
            errors++;
            $display("FAIL full_accepted got %0d expected 5", n_ok);
        end
        checks++;
        if (ce_cyc.size() != 20 || rv_data.size() != 20) begin
            errors++;
            $display("FAIL full_counts got beats=%0d rvalids=%0d expected 20 20", ce_cyc.size(), rv_data.size());
        end else begin
            for (int j = 0; j < 20; j++) begin
                ea = 8'h40 + 8'(16 * (j / 4)) + 8'(j % 4);
                checks++;
                if (ce_bus[j] !== {1'b0, ea, 8'h00} || ce_cyc[j] != acc[0] + 2 + j) begin
                    errors++;
                    $display("FAIL full_beat%0d got bus=%h at cyc+%0d expected addr %h at cyc+%0d",
                             j, ce_bus[j], ce_cyc[j] - acc[0], ea, 2 + j);
                end
                checks++;
                if (rv_data[j] !== (ea ^ 8'h5A) || rv_cyc[j] != acc[0] + 4 + j) begin
                    errors++;
                    $display("FAIL full_rdata%0d got %h at cyc+%0d expected %h at cyc+%0d",
                             j, rv_data[j], rv_cyc[j] - acc[0], ea ^ 8'h5A, 4 + j);
                end
            end
        end
    endtask

    task automatic test_rd_lat3();
        int a;
        @(negedge clk);
        cmd_valid3 = 1'b1;
        we3 = 1'b0;
        addr3 = 8'h33;
        wdata3 = 8'h00;
        blen3 = 2'd0;
        a = cyc + 1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            checks++;
            if (rvalid3 !== (k == 6)) begin
                errors++;
                $display("FAIL lat3_rvalid_cyc%0d got %b expected %b", k, rvalid3, (k == 6));
            end
            checks++;
            if (idle3 !== (k >= 7)) begin
                errors++;
                $display("FAIL lat3_idle_cyc%0d got %b expected %b", k, idle3, (k >= 7));
            end
            if (k == 6) begin
                checks++;
                if (rdata3 !== 8'h69) begin
                    errors++;
                    $display("FAIL lat3_rdata got %h expected 69", rdata3);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (cyc != a + 9) begin
            errors++;
            $display("FAIL lat3_cycle_count got cyc+%0d expected cyc+9", cyc - a);
        end
    endtask

    task automatic test_reset_mid();
        int a, t;
        logic ok;
        int n_rv, n_ce;
        send(1'b0, 8'h40, 8'h00, 2'd3, a, ok);
        send(1'b0, 8'h50, 8'h00, 2'd3, t, ok);
        drop();
        @(negedge clk);
        checks++;
        if (ce_mem !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy got ce=%b expected 1", ce_mem);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ce_mem, we_mem, addr_mem, datai_mem, rdata, rvalid, ready, idle} !== {2'b00, 8'h00, 8'h00, 8'h00, 3'b001}) begin
            errors++;
            $display("FAIL rstmid_outputs got ce=%b we=%b addr=%h di=%h rd=%h rv=%b rdy=%b idle=%b, expected 0 0 00 00 00 0 0 1",
                     ce_mem, we_mem, addr_mem, datai_mem, rdata, rvalid, ready, idle);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b expected 1", ready);
        end
        n_rv = 0;
        n_ce = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid) n_rv++;
            if (ce_mem) n_ce++;
        end
        checks++;
        if (n_rv != 0 || n_ce != 0) begin
            errors++;
            $display("FAIL rstmid_activity got rvalids=%0d beats=%0d expected 0 0", n_rv, n_ce);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle got %b expected 1", idle);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_wrap();
        test_full();
        test_rd_lat3();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
